dmem_arbiter: RTL and testbench

Two-port arbiter that shares the single-ported data memory between the pipelined CPU's MEM stage and a DMA/debug loader port. The CPU has priority by default. A starvation counter guarantees the DMA port a bounded wait, after which the DMA port gets a short priority burst while the CPU is stalled. The block sits between the MEM stage, the DMA engine and the data memory, and drives the memory's read/write/address/data inputs.

---
 rtl/dmem_arbiter.sv | 91 +++++++++
 tb/tb_dmem_arbiter.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the data memory between the CPU MEM stage and a DMA/debug port.
// The CPU has priority until the DMA port has waited WAIT_LIMIT cycles; then the DMA port gets a bounded burst.
module dmem_arbiter #(
   parameter int WAIT_LIMIT = 4,
   parameter int BURST_MAX  = 4,
   parameter int CNT_W      = 3
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_wdata,
   output logic [31:0] cpu_rdata,
   output logic        cpu_stall,
   input  logic        dma_req,
   input  logic        dma_we,
   input  logic [31:0] dma_addr,
   input  logic [31:0] dma_wdata,
   output logic        dma_ack,
   output logic [31:0] dma_rdata,
   output logic        dma_rvalid,
   output logic        dma_err,
   output logic        mem_read,
   output logic        mem_write,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   output logic        dma_mode
);
   typedef enum logic {CPU_PRI, DMA_PRI} state_e;
   localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'(WAIT_LIMIT - 1);
   localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(BURST_MAX - 1);
   state_e            state_q, state_d;
   logic [CNT_W-1:0]  wait_q, wait_d, burst_q, burst_d;
   logic [31:0]       dma_rdata_q, dma_rdata_d;
   logic              dma_rvalid_q, dma_rvalid_d, dma_err_q, dma_err_d;
   logic              cpu_grant, dma_grant, dma_mmio, dma_ram;
   // Reset blocks every grant so nothing reaches memory while it is held.
   assign dma_mmio  = dma_addr >= 32'h4000_0000;
   assign cpu_grant = ~reset & cpu_req & ((state_q == CPU_PRI) | ~dma_req);
   assign dma_grant = ~reset & dma_req & ~cpu_grant;
   assign dma_ram   = dma_grant & ~dma_mmio;
   assign cpu_stall = ~reset & cpu_req & ~cpu_grant;
   assign dma_ack   = dma_grant;
   assign cpu_rdata = (cpu_grant & ~cpu_we) ? mem_rdata : '0;
   assign mem_read  = (cpu_grant & ~cpu_we) | (dma_ram & ~dma_we);
   assign mem_write = (cpu_grant & cpu_we) | (dma_ram & dma_we);
   assign mem_addr  = cpu_grant ? cpu_addr : dma_ram ? dma_addr : '0;
   assign mem_wdata = cpu_grant ? cpu_wdata : dma_ram ? dma_wdata : '0;
   assign dma_mode   = state_q == DMA_PRI;
   assign dma_rdata  = dma_rdata_q;
   assign dma_rvalid = dma_rvalid_q;
   assign dma_err    = dma_err_q;
   always_comb begin
      state_d = state_q;
      wait_d  = '0;
      burst_d = burst_q;
      if (state_q == CPU_PRI) begin
         if (dma_req & ~dma_grant) begin
            wait_d  = (wait_q == WAIT_LAST) ? '0 : wait_q + 1'b1;
            state_d = (wait_q == WAIT_LAST) ? DMA_PRI : CPU_PRI;
         end
      end else if (~dma_req | (burst_q == BURST_LAST)) begin
         state_d = CPU_PRI;
         burst_d = '0;
      end else begin
         burst_d = burst_q + 1'b1;
      end
      dma_rvalid_d = dma_grant & (~dma_we | dma_mmio);
      dma_err_d    = dma_grant & dma_mmio;
      dma_rdata_d  = dma_rvalid_d ? (dma_mmio ? '0 : mem_rdata) : dma_rdata_q;
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= CPU_PRI;
         wait_q       <= '0;
         burst_q      <= '0;
         dma_rdata_q  <= '0;
         dma_rvalid_q <= 1'b0;
         dma_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         wait_q       <= wait_d;
         burst_q      <= burst_d;
         dma_rdata_q  <= dma_rdata_d;
         dma_rvalid_q <= dma_rvalid_d;
         dma_err_q    <= dma_err_d;
      end
   end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed and random traffic against a queue-based scoreboard and a behavioural model.
module tb_dmem_arbiter;
   localparam int WAIT_LIMIT = 4;
   localparam int BURST_MAX  = 4;
   logic clk, reset;
   logic cpu_req, cpu_we, dma_req, dma_we;
   logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
   logic [31:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata, mem_rdata;
   logic cpu_stall, dma_ack, dma_rvalid, dma_err, mem_read, mem_write, dma_mode;
   dmem_arbiter #(.WAIT_LIMIT(WAIT_LIMIT), .BURST_MAX(BURST_MAX), .CNT_W(3)) dut (
      .clk(clk), .reset(reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
      .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
      .dma_ack(dma_ack), .dma_rdata(dma_rdata), .dma_rvalid(dma_rvalid), .dma_err(dma_err),
      .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .dma_mode(dma_mode)
   );
   typedef struct {
      bit stall, ack, mrd, mwr, mode, rvalid, err;
      logic [31:0] maddr, mwd, crd, rdata;
   } exp_t;
   exp_t q[$];
   logic [31:0] ram [64];
   logic [31:0] ref_mem [64];
   int vectors = 0, miscompares = 0;
   bit m_dma = 0, p_rvalid = 0, p_err = 0, dma_hold = 0;
   int m_wait = 0, m_burst = 0;
   logic [31:0] p_rdata = 0;
   initial clk = 0;
   always #5 clk = ~clk;
   // The memory answers combinationally and commits writes at the clock edge.
   assign mem_rdata = ram[mem_addr[7:2]];
   always @(posedge clk) if (mem_write) ram[mem_addr[7:2]] <= mem_wdata;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask
   always @(negedge clk) begin
      if (q.size() != 0) begin
         exp_t e;
         e = q.pop_front();
         vectors++;
         chk("cpu_stall", 32'(cpu_stall), 32'(e.stall));
         chk("dma_ack", 32'(dma_ack), 32'(e.ack));
         chk("mem_read", 32'(mem_read), 32'(e.mrd));
         chk("mem_write", 32'(mem_write), 32'(e.mwr));
         chk("mem_addr", mem_addr, e.maddr);
         chk("mem_wdata", mem_wdata, e.mwd);
         chk("cpu_rdata", cpu_rdata, e.crd);
         chk("dma_mode", 32'(dma_mode), 32'(e.mode));
         chk("dma_rvalid", 32'(dma_rvalid), 32'(e.rvalid));
         chk("dma_err", 32'(dma_err), 32'(e.err));
         if (e.rvalid) chk("dma_rdata", dma_rdata, e.rdata);
      end
   end
   // One cycle of stimulus; the model predicts this cycle's outputs and advances.
   task automatic cyc(input bit r, input bit cr, input bit cw, input logic [31:0] ca, input logic [31:0] cd,
                      input bit dr, input bit dw, input logic [31:0] da, input logic [31:0] dd);
      exp_t e;
      bit cg, dg, mm;
      @(posedge clk);
      #1;
      reset = r; cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
      dma_req = dr; dma_we = dw; dma_addr = da; dma_wdata = dd;
      mm = da >= 32'h4000_0000;
      cg = !r && cr && (!m_dma || !dr);
      dg = !r && dr && !cg;
      e.stall  = !r && cr && !cg;
      e.ack    = dg;
      e.mrd    = (cg && !cw) || (dg && !mm && !dw);
      e.mwr    = (cg && cw) || (dg && !mm && dw);
      e.maddr  = cg ? ca : (dg && !mm) ? da : 32'h0;
      e.mwd    = cg ? cd : (dg && !mm) ? dd : 32'h0;
      e.crd    = (cg && !cw) ? ref_mem[ca[7:2]] : 32'h0;
      e.mode   = !r && m_dma;
      e.rvalid = !r && p_rvalid;
      e.err    = !r && p_err;
      e.rdata  = p_rdata;
      q.push_back(e);
      if (r) begin
         m_dma = 0; m_wait = 0; m_burst = 0; p_rvalid = 0; p_err = 0; p_rdata = 0;
      end else begin
         if (!m_dma) begin
            if (dr && !dg) begin
               m_wait++;
               if (m_wait == WAIT_LIMIT) begin m_dma = 1; m_wait = 0; end
            end else m_wait = 0;
         end else if (!dr) begin
            m_dma = 0; m_burst = 0;
         end else begin
            m_burst++;
            if (m_burst == BURST_MAX) begin m_dma = 0; m_burst = 0; end
         end
         p_rvalid = dg && (!dw || mm);
         p_err = dg && mm;
         if (p_rvalid) p_rdata = mm ? 32'h0 : ref_mem[da[7:2]];
         if (cg && cw) ref_mem[ca[7:2]] = cd;
         if (dg && dw && !mm) ref_mem[da[7:2]] = dd;
      end
      dma_hold = !r && dr && !dg;
   endtask
   initial begin
      logic [31:0] ca, da;
      bit cr, cw, dr, dw, r;
      for (int i = 0; i < 64; i++) begin
         ram[i] = (i == 0) ? 32'hFFFF_FFD3 : 32'(i) * 32'h0101_0101;
         ref_mem[i] = ram[i];
      end
      reset = 1; cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
      dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0;
      repeat (2) cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 1, 1, 32'h20, 32'hAB);
      cyc(0, 0, 0, 0, 0, 1, 0, 32'h20, 0);
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
      cyc(0, 1, 0, 32'h0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 1, 1, 32'h4000_0010, 32'h55);
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
      cyc(0, 1, 0, 32'h4000_0010, 0, 0, 0, 0, 0);
      for (int i = 0; i < 18; i++) cyc(0, 1, i[0], 32'h4, 32'(i), 1, 0, 32'h20, 0);
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 6; i++) cyc(0, 1, 0, 32'h8, 0, 1, 0, 32'h24, 0);
      repeat (2) cyc(0, 1, 0, 32'h8, 0, 0, 0, 0, 0);
      for (int i = 0; i < 6; i++) cyc(0, 1, 0, 32'hC, 0, 1, 0, 32'h28, 0);
      cyc(1, 1, 0, 32'hC, 0, 1, 0, 32'h28, 0);
      for (int i = 0; i < 10; i++) cyc(0, 1, 0, 32'hC, 0, 1, 0, 32'h28, 0);
      for (int i = 0; i < 2000; i++) begin
         r  = $urandom_range(0, 60) == 0;
         cr = $urandom_range(0, 3) != 0;
         cw = $urandom_range(0, 2) == 0;
         ca = 32'($urandom_range(0, 63)) << 2;
         if (dma_hold) begin
            dr = 1; dw = dma_we; da = dma_addr;
            cyc(r, cr, cw, ca, $urandom, dr, dw, da, dma_wdata);
         end else begin
            dr = $urandom_range(0, 2) != 0;
            dw = $urandom_range(0, 1) == 0;
            da = (32'($urandom_range(0, 63)) << 2) | (($urandom_range(0, 7) == 0) ? 32'h4000_0000 : 32'h0);
            cyc(r, cr, cw, ca, $urandom, dr, dw, da, $urandom);
         end
      end
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
      repeat (2) @(negedge clk);
      if (q.size() != 0) begin
         miscompares++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
